// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module     : debounce_pkg
//  Description: Shared types and helpers for the multi-channel debouncer.
//               - c_DEF_STABLE_TICKS / c_DEF_REPEAT_TICKS : default timings
//               - debounce_status_t : per-channel {level, rise, fall, rpt}
//               - cnt_width()       : bits needed to hold a count up to max_val
//  Revision   : 1.0  initial release
// ============================================================================
package debounce_pkg;

    localparam int c_DEF_STABLE_TICKS = 50;
    localparam int c_DEF_REPEAT_TICKS = 0;

    // "rpt" carries the auto-repeat strobe ("repeat" is a reserved word).
    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
        logic rpt;
    } debounce_status_t;

    // Smallest width (>=1) able to represent 0..max_val.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w++;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module     : debounce_channel
//  Description: One debounce lane: two-flop synchroniser, saturating stability
//               counter, registered level/rise/fall and optional auto-repeat.
//  Ports      : clk      in  system clock (posedge)
//               rst      in  synchronous active-high reset
//               i_tick   in  count enable
//               i_signal in  raw asynchronous input
//               o_status out {level, rise, fall, rpt}, all registered
//  Revision   : 1.0  initial release
// ============================================================================
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = c_DEF_STABLE_TICKS,
    parameter int REPEAT_TICKS = c_DEF_REPEAT_TICKS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic             i_signal,
    output debounce_status_t o_status
);

    localparam int                    c_CNT_BITS = cnt_width(STABLE_TICKS);
    localparam logic [c_CNT_BITS-1:0] c_CNT_MAX  = c_CNT_BITS'(STABLE_TICKS);

    logic [1:0]            r_sync;
    logic                  r_prev;
    logic [c_CNT_BITS-1:0] r_cnt;
    logic                  r_level;
    logic                  r_rise;
    logic                  r_fall;
    logic                  w_changed;
    logic                  w_update;
    logic                  w_rpt;

    // r_prev lags r_sync[1] by one clock, so a difference marks a fresh edge
    // on the synchronised input.
    assign w_changed = r_sync[1] ^ r_prev;
    assign w_update  = (r_cnt == c_CNT_MAX) && (r_prev != r_level);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_prev  <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_signal};
            r_prev <= r_sync[1];

            // A fresh edge restarts the stability window even with tick low.
            if (w_changed) begin
                r_cnt <= '0;
            end else if (i_tick && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + c_CNT_BITS'(1);
            end

            r_rise <= w_update &&  r_prev;
            r_fall <= w_update && !r_prev;
            if (w_update) begin
                r_level <= r_prev;
            end
        end
    end

    generate
        if (REPEAT_TICKS > 0) begin : g_repeat
            localparam int                    c_REP_BITS = cnt_width(REPEAT_TICKS) + 1;
            localparam logic [c_REP_BITS-1:0] c_REP_LAST = c_REP_BITS'(REPEAT_TICKS - 1);

            logic [c_REP_BITS-1:0] r_rcnt;
            logic                  r_rpt;

            // Any level update (rise or fall) restarts the repeat interval, and a
            // fall therefore never coincides with a repeat strobe.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rcnt <= '0;
                    r_rpt  <= 1'b0;
                end else if (w_update || !r_level) begin
                    r_rcnt <= '0;
                    r_rpt  <= 1'b0;
                end else if (i_tick) begin
                    if (r_rcnt == c_REP_LAST) begin
                        r_rcnt <= '0;
                        r_rpt  <= 1'b1;
                    end else begin
                        r_rcnt <= r_rcnt + c_REP_BITS'(1);
                        r_rpt  <= 1'b0;
                    end
                end else begin
                    r_rpt <= 1'b0;
                end
            end

            assign w_rpt = r_rpt;
        end else begin : g_no_repeat
            assign w_rpt = 1'b0;
        end
    endgenerate

    assign o_status.level = r_level;
    assign o_status.rise  = r_rise;
    assign o_status.fall  = r_fall;
    assign o_status.rpt   = w_rpt;

endmodule
`default_nettype wire

// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
//  Module     : debounce_multi
//  Description: NUM_CH independent switch/button debouncers with rise/fall
//               strobes and optional auto-repeat.
//  Ports      : in_clk        in  system clock (posedge)
//               in_rst        in  synchronous active-high reset
//               in_tick       in  count enable (prescaler strobe)
//               in_signal     in  [NUM_CH] raw asynchronous inputs
//               out_debounced out [NUM_CH] debounced levels
//               out_rise      out [NUM_CH] 1-cycle strobe on debounced 0->1
//               out_fall      out [NUM_CH] 1-cycle strobe on debounced 1->0
//               out_repeat    out [NUM_CH] 1-cycle auto-repeat strobe
//  Revision   : 1.0  initial release
// ============================================================================
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int STABLE_TICKS = c_DEF_STABLE_TICKS,
    parameter int REPEAT_TICKS = c_DEF_REPEAT_TICKS
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_tick,
    input  logic [NUM_CH-1:0] in_signal,
    output logic [NUM_CH-1:0] out_debounced,
    output logic [NUM_CH-1:0] out_rise,
    output logic [NUM_CH-1:0] out_fall,
    output logic [NUM_CH-1:0] out_repeat
);

    debounce_status_t w_status [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            debounce_channel #(
                .STABLE_TICKS(STABLE_TICKS),
                .REPEAT_TICKS(REPEAT_TICKS)
            ) u_channel (
                .clk     (in_clk),
                .rst     (in_rst),
                .i_tick  (in_tick),
                .i_signal(in_signal[gi]),
                .o_status(w_status[gi])
            );

            assign out_debounced[gi] = w_status[gi].level;
            assign out_rise[gi]      = w_status[gi].rise;
            assign out_fall[gi]      = w_status[gi].fall;
            assign out_repeat[gi]    = w_status[gi].rpt;
        end
    endgenerate

endmodule
`default_nettype wire
